// File: rtl/sync_lib_pkg.sv
// Shared constants and width helpers for the synchroniser library blocks.
package sync_lib_pkg;

    localparam int SYNC_MIN_STAGES = 2;

    function automatic int clog2(input int value);
        int w;
        int v;
        w = 0;
        v = value - 1;
        while (v > 0) begin
            w++;
            v = v >>> 1;
        end
        return w;
    endfunction

    // Counter width never drops below one bit, even when no filtering is needed.
    function automatic int cnt_width(input int n);
        return (clog2(n) < 1) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One synchroniser channel: STAGES-deep flop chain, persistence filter and edge pulses.
module sync_filter_chan
    import sync_lib_pkg::*;
#(
    parameter int   STAGES   = 2,
    parameter int   FILT_CYC = 1,
    parameter logic RST_VAL  = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic in_sig,
    output logic sync_sig,
    output logic rise,
    output logic fall,
    output logic pulse_nxt
);

    localparam int CW = cnt_width(FILT_CYC);
    localparam logic [CW-1:0] CNT_MAX = CW'(FILT_CYC - 1);

    if (STAGES < SYNC_MIN_STAGES || FILT_CYC < 1) begin : g_bad_param
        $error("sync_filter_chan: STAGES must be >= 2 and FILT_CYC >= 1");
    end

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_p;
    logic          raw;
    logic [CW-1:0] cnt;

    assign raw       = sync_p[STAGES-1];
    assign pulse_nxt = (raw != sync_sig) && (cnt == CNT_MAX);

    // Synchroniser chain: pure flop-to-flop, no logic between stages
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p <= {STAGES{RST_VAL}};
        end else begin
            sync_p <= {sync_p[STAGES-2:0], in_sig};
        end
    end

    // Filter / accept stage
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_sig <= RST_VAL;
            cnt      <= '0;
            rise     <= 1'b0;
            fall     <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (raw == sync_sig) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                sync_sig <= raw;
                cnt      <= '0;
                rise     <= raw;
                fall     <= ~raw;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/sync_filter_bank.sv
// NCH independent filtered synchronisers with a shared "any channel changed" flag.
module sync_filter_bank
    import sync_lib_pkg::*;
#(
    parameter int NCH      = 1,
    parameter int STAGES   = 2,
    parameter int FILT_CYC = 1,
    parameter     RST_VAL  = {NCH{1'b0}}
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] in_sig,
    output logic [NCH-1:0] sync_sig,
    output logic [NCH-1:0] rise,
    output logic [NCH-1:0] fall,
    output logic           chg_any
);

    if ($bits(RST_VAL) != NCH) begin : g_bad_rst_val
        $error("sync_filter_bank: RST_VAL width must equal NCH");
    end
    if (STAGES < SYNC_MIN_STAGES || FILT_CYC < 1) begin : g_bad_param
        $error("sync_filter_bank: STAGES must be >= 2 and FILT_CYC >= 1");
    end

    localparam logic [NCH-1:0] RST_V = RST_VAL;

    logic [NCH-1:0] pulse_nxt;

    for (genvar i = 0; i < NCH; i++) begin : g_chan
        sync_filter_chan #(
            .STAGES   (STAGES),
            .FILT_CYC (FILT_CYC),
            .RST_VAL  (RST_V[i])
        ) u_chan (
            .clk       (clk),
            .rst       (rst),
            .in_sig    (in_sig[i]),
            .sync_sig  (sync_sig[i]),
            .rise      (rise[i]),
            .fall      (fall[i]),
            .pulse_nxt (pulse_nxt[i])
        );
    end

    // Registered from the channels' next-cycle pulse so it lines up with rise/fall
    always_ff @(posedge clk) begin
        if (rst) begin
            chg_any <= 1'b0;
        end else begin
            chg_any <= |pulse_nxt;
        end
    end

endmodule

// File: tb/tb_sync_filter_bank.sv
// Randomised and directed bench for sync_filter_bank, two parameterisations against a window-scan model.
module tb_sync_filter_bank;

    localparam int NCH  = 4;
    localparam int HMAX = 16384;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic [NCH-1:0] in_sig = '0;

    logic [NCH-1:0] sync_a, rise_a, fall_a;
    logic [NCH-1:0] sync_b, rise_b, fall_b;
    logic           chg_a, chg_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sync_filter_bank #(.NCH(NCH), .STAGES(3), .FILT_CYC(4), .RST_VAL(4'b1010)) dut_a (
        .clk(clk), .rst(rst), .in_sig(in_sig),
        .sync_sig(sync_a), .rise(rise_a), .fall(fall_a), .chg_any(chg_a)
    );

    sync_filter_bank #(.NCH(NCH), .STAGES(2), .FILT_CYC(1), .RST_VAL(4'b1010)) dut_b (
        .clk(clk), .rst(rst), .in_sig(in_sig),
        .sync_sig(sync_b), .rise(rise_b), .fall(fall_b), .chg_any(chg_b)
    );

    // Reference model: model 0 mirrors dut_a's parameters, model 1 dut_b's.
    // A level is accepted when the synchronised value has differed from the
    // current level on each of the last FILT_CYC edges since the last event.
    int              m_stg[2] = '{3, 2};
    int              m_flt[2] = '{4, 1};
    logic [NCH-1:0]  m_pipe[2][8];
    logic [NCH-1:0]  m_lvl[2];
    logic [NCH-1:0]  m_rise[2];
    logic [NCH-1:0]  m_fall[2];
    logic            m_chg[2];
    logic [NCH-1:0]  m_rawh[2][HMAX];
    int              m_last[2][NCH];
    int              m_t[2] = '{0, 0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s obs=%0h exp=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge(input int m, input logic r, input logic [NCH-1:0] din);
        logic [NCH-1:0] raw;
        bit             ok;
        int             idx;
        int             t;
        t = m_t[m];
        if (r) begin
            for (int k = 0; k < 8; k++) m_pipe[m][k] = 4'b1010;
            m_lvl[m]  = 4'b1010;
            m_rise[m] = '0;
            m_fall[m] = '0;
            m_chg[m]  = 1'b0;
            for (int c = 0; c < NCH; c++) m_last[m][c] = t;
        end else begin
            raw = m_pipe[m][m_stg[m]-1];
            m_rawh[m][t] = raw;
            m_rise[m] = '0;
            m_fall[m] = '0;
            for (int c = 0; c < NCH; c++) begin
                ok = 1'b1;
                for (int k = 0; k < m_flt[m]; k++) begin
                    idx = t - k;
                    if (idx <= m_last[m][c]) ok = 1'b0;
                    else if (m_rawh[m][idx][c] == m_lvl[m][c]) ok = 1'b0;
                end
                if (ok) begin
                    m_lvl[m][c]  = raw[c];
                    m_rise[m][c] = raw[c];
                    m_fall[m][c] = ~raw[c];
                    m_last[m][c] = t;
                end
            end
            for (int k = m_stg[m]-1; k > 0; k--) m_pipe[m][k] = m_pipe[m][k-1];
            m_pipe[m][0] = din;
            m_chg[m] = |(m_rise[m] | m_fall[m]);
        end
        if (m_t[m] < HMAX - 1) m_t[m] = t + 1;
    endtask

    task automatic step();
        logic           r;
        logic [NCH-1:0] d;
        r = rst;
        d = in_sig;
        @(posedge clk);
        model_edge(0, r, d);
        model_edge(1, r, d);
        #1;
        check("a_sync", sync_a, m_lvl[0]);
        check("a_rise", rise_a, m_rise[0]);
        check("a_fall", fall_a, m_fall[0]);
        check("a_chg",  chg_a,  m_chg[0]);
        check("b_sync", sync_b, m_lvl[1]);
        check("b_rise", rise_b, m_rise[1]);
        check("b_fall", fall_b, m_fall[1]);
        check("b_chg",  chg_b,  m_chg[1]);
        check("rise_fall_excl", |((rise_a & fall_a) | (rise_b & fall_b)), 1'b0);
    endtask

    initial begin
        int na, nb, tr, tf, width, cnt_b, cnt_a, alt_err;
        logic quiet;
        logic last_rise;

        // 1: reset hold with inputs opposite to the reset level
        rst = 1'b1;
        in_sig = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_sync_a", sync_a, 4'b1010);
            check("rst_sync_b", sync_b, 4'b1010);
            check("rst_quiet", {rise_a, fall_a, chg_a, rise_b, fall_b, chg_b}, '0);
        end
        rst = 1'b0;
        na = 0; nb = 0;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (chg_a && na == 0) begin
                na = n;
                check("rel_rise_a", rise_a, 4'b0101);
                check("rel_fall_a", fall_a, 4'b1010);
            end
            if (chg_b && nb == 0) begin
                nb = n;
                check("rel_rise_b", rise_b, 4'b0101);
                check("rel_fall_b", fall_b, 4'b1010);
            end
        end
        check("rel_lat_a", na, 7);
        check("rel_lat_b", nb, 3);

        // 2: single rising level on channel 0
        in_sig = 4'b0100;
        for (int i = 0; i < 10; i++) step();
        in_sig = 4'b0101;
        na = 0; nb = 0; width = 0;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (rise_a[0]) begin
                width++;
                if (na == 0) na = n;
            end
            if (rise_b[0] && nb == 0) nb = n;
        end
        check("ch0_lat_a", na, 7);
        check("ch0_lat_b", nb, 3);
        check("ch0_width_a", width, 1);
        check("ch0_level_a", sync_a[0], 1'b1);

        // 3: glitch shorter than the filter, then one exactly as long
        quiet = 1'b0;
        in_sig[1] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            quiet |= sync_a[1] | rise_a[1] | fall_a[1] | chg_a;
        end
        in_sig[1] = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            quiet |= sync_a[1] | rise_a[1] | fall_a[1] | chg_a;
        end
        check("glitch3_quiet_a", quiet, 1'b0);
        tr = 0; tf = 0;
        in_sig[1] = 1'b1;
        for (int n = 1; n <= 24; n++) begin
            if (n == 5) in_sig[1] = 1'b0;
            step();
            if (rise_a[1] && tr == 0) tr = n;
            if (fall_a[1] && tf == 0) tf = n;
        end
        check("pulse4_rise_a", tr, 7);
        check("pulse4_gap_a", tf - tr, 4);

        // 4: toggling every 2 cycles on channel 2
        cnt_a = 0; cnt_b = 0; alt_err = 0;
        last_rise = 1'b1;
        for (int n = 0; n < 22; n++) begin
            if (n < 16 && n % 2 == 0) in_sig[2] = ~in_sig[2];
            step();
            if (rise_a[2] | fall_a[2]) cnt_a++;
            if (rise_b[2] | fall_b[2]) begin
                cnt_b++;
                if (rise_b[2] == last_rise) alt_err++;
                last_rise = rise_b[2];
            end
        end
        check("toggle_pulses_b", cnt_b, 8);
        check("toggle_alt_b", alt_err, 0);
        check("toggle_hold_a", cnt_a, 0);

        // 5: reset while channel 3 is mid-filter
        in_sig[3] = 1'b1;
        for (int i = 0; i < 5; i++) step();
        check("pend_no_pulse_a", rise_a[3] | sync_a[3], 1'b0);
        rst = 1'b1;
        step();
        check("rst_mid_nopulse", {chg_a, chg_b}, 2'b00);
        rst = 1'b0;
        na = 0;
        for (int n = 1; n <= 12; n++) begin
            step();
            if (chg_a && na == 0) na = n;
        end
        check("rst_mid_lat_a", na, 7);

        // 6: random slowly-flipping inputs with occasional reset
        for (int n = 0; n < 10000; n++) begin
            logic [NCH-1:0] flip;
            for (int c = 0; c < NCH; c++) flip[c] = ($urandom_range(0, 3) == 0);
            in_sig = in_sig ^ flip;
            rst = ($urandom_range(0, 299) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
